hilo_div_unit: RTL

Architectural HI/LO register pair plus the iterative divider that feeds it. It sits at the tail of the pipeline and consumes the `whilo`/`hi`/`lo` write group after it has left the memory stage. It also exposes the current (bypassed) HI/LO values to execute for MFHI/MFLO and madd-style use. DIV/DIVU operands come from execute; the 64-bit result returns to execute, travels down the pipe, and comes back in through the write port.

---
 rtl/hilo_div_unit_pkg.sv | 32 +++
 rtl/hilo_div_unit_div_core.sv | 126 ++++++++++++
 rtl/hilo_div_unit.sv | 63 ++++++
 3 files changed

// File: rtl/hilo_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_div_unit_pkg
// Description : Shared types and constants for the HI/LO register pair and divider
// Revision    : 1.0 - initial release
// ============================================================================
package hilo_div_unit_pkg;

  typedef logic [31:0] Reg_t;
  typedef logic [63:0] DReg_t;

  typedef enum logic [1:0] {
    DivFree   = 2'd0,
    DivByZero = 2'd1,
    DivOn     = 2'd2,
    DivEnd    = 2'd3
  } div_state_t;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [5:0] DivLastStep = 6'd31;

  // Magnitude of an operand; unsigned operands pass through untouched.
  function automatic Reg_t abs_val(input logic is_signed, input Reg_t x);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_div_unit_div_core.sv
`default_nettype none
// ============================================================================
// Module      : hilo_div_unit_div_core
// Description : 32-step restoring divider with sign fix-up and annul support
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_div_unit_div_core
  import hilo_div_unit_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  logic  is_signed,
  input  Reg_t  opdata1,
  input  Reg_t  opdata2,
  input  logic  annul,
  output DReg_t result,
  output logic  ready
);

  div_state_t  state_q, state_d;
  logic [64:0] work_q, work_d;
  Reg_t        divisor_q, divisor_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sign1_q, sign1_d;
  logic        sign2_q, sign2_d;
  logic        signed_q, signed_d;
  DReg_t       result_q, result_d;

  logic [64:0] shifted;
  logic [33:0] diff;
  logic [64:0] step_work;
  Reg_t        quot_fix;
  Reg_t        rem_fix;

  // One restoring step: shift, trial-subtract from the upper 33 bits, keep if non-negative.
  always_comb begin
    shifted   = work_q << 1;
    diff      = {1'b0, shifted[64:32]} - {2'b00, divisor_q};
    step_work = diff[33] ? shifted : {diff[32:0], shifted[31:1], 1'b1};
    quot_fix  = (signed_q && (sign1_q ^ sign2_q)) ? (~step_work[31:0] + 32'd1) : step_work[31:0];
    rem_fix   = (signed_q && sign1_q) ? (~step_work[63:32] + 32'd1) : step_work[63:32];
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    signed_d  = signed_q;
    result_d  = result_q;
    case (state_q)
      DivFree: begin
        if (start == DivStart && !annul) begin
          if (opdata2 == '0) begin
            state_d = DivByZero;
          end else begin
            state_d   = DivOn;
            work_d    = {33'd0, abs_val(is_signed, opdata1)};
            divisor_d = abs_val(is_signed, opdata2);
            cnt_d     = '0;
            sign1_d   = opdata1[31];
            sign2_d   = opdata2[31];
            signed_d  = is_signed;
          end
        end
      end
      DivByZero: begin
        if (annul) begin
          state_d = DivFree;
        end else begin
          result_d = '0;
          state_d  = DivEnd;
        end
      end
      DivOn: begin
        if (annul) begin
          state_d = DivFree;
        end else begin
          work_d = step_work;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == DivLastStep) begin
            result_d = {rem_fix, quot_fix};
            state_d  = DivEnd;
          end
        end
      end
      DivEnd: begin
        if (annul || start == DivStop) begin
          state_d  = DivFree;
          result_d = '0;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DivFree;
      work_q    <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      signed_q  <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      signed_q  <= signed_d;
      result_q  <= result_d;
    end
  end

  assign ready  = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
  assign result = (state_q == DivEnd) ? result_q : '0;

endmodule
`default_nettype wire

// File: rtl/hilo_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_div_unit
// Description : HI/LO register pair with write-through bypass and attached divider
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_div_unit
  import hilo_div_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         whilo_i,
  input  logic [31:0]  hi_i,
  input  logic [31:0]  lo_i,
  output logic [31:0]  hi_o,
  output logic [31:0]  lo_o,
  input  logic         div_start_i,
  input  logic         div_signed_i,
  input  logic [31:0]  div_opdata1_i,
  input  logic [31:0]  div_opdata2_i,
  input  logic         div_annul_i,
  output logic [63:0]  div_result_o,
  output logic         div_ready_o,
  output logic         stallreq_o
);

  Reg_t  hi_q;
  Reg_t  lo_q;
  logic  div_ready;
  DReg_t div_result;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (whilo_i) begin
      hi_q <= hi_i;
      lo_q <= lo_i;
    end
  end

  // Write-through so execute sees a value that has not yet reached the registers.
  assign hi_o = whilo_i ? hi_i : hi_q;
  assign lo_o = whilo_i ? lo_i : lo_q;

  hilo_div_unit_div_core u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_i),
    .is_signed (div_signed_i),
    .opdata1   (div_opdata1_i),
    .opdata2   (div_opdata2_i),
    .annul     (div_annul_i),
    .result    (div_result),
    .ready     (div_ready)
  );

  assign div_result_o = div_result;
  assign div_ready_o  = div_ready;
  assign stallreq_o   = div_start_i & ~div_ready & ~div_annul_i;

endmodule
`default_nettype wire
